ahb_slave_mem: RTL

AHB-lite responder for the bridge bench: the slave end of the bus driven by our AHB master. It decodes single and incrementing/wrapping burst transfers (NONSEQ/SEQ), services them from an internal word memory with byte/halfword/word lanes, and inserts programmable wait states. It returns a two-cycle ERROR response for illegal accesses. It lets master tasks be exercised stand-alone, without the APB side.

---
 rtl/ahb_slave_mem.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/ahb_slave_mem.sv
// AHB-lite word-memory responder with byte/halfword/word lanes and WAIT_STATES wait states; ERROR response built
// only when AHB_SLAVE_ERR_RESP_EN is defined. Data phase is WAIT_STATES+1 cycles (2 for errors); hreadyout low extends it.
module ahb_slave_mem #(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          MEM_WORDS   = 64,
  parameter int          WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hreadyin,
  output logic        hreadyout,
  output logic [1:0]  hresp,
  output logic [31:0] hrdata
);

  localparam int          AW        = $clog2(MEM_WORDS);
  localparam logic [31:0] WIN_BYTES = 32'(MEM_WORDS * 4);
  localparam logic [2:0]  WS        = 3'(WAIT_STATES);

  typedef struct packed {
    logic          vld;
    logic          write;
    logic          err;
    logic [3:0]    be;
    logic [AW-1:0] idx;
  } pend_t;

`ifdef AHB_SLAVE_ERR_RESP_EN
  typedef enum logic [1:0] {ST_READY, ST_WAIT, ST_ERR1, ST_ERR2} state_t;
`else
  typedef enum logic [1:0] {ST_READY, ST_WAIT} state_t;
`endif

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  pend_t         pend;
  logic [31:0]   mem [MEM_WORDS];
  logic [31:0]   offset;
  logic          illegal, acc, commit;
  logic [AW-1:0] rd_idx;
  logic [3:0]    be_in;
  logic [31:0]   wr_word, fwd_word;
  logic          unused_bits;

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    end
    return res;
  endfunction

  assign unused_bits = htrans[0];
  assign offset      = haddr - ADDR_BASE;
  assign rd_idx      = offset[AW+1:2];
  assign illegal     = (offset >= WIN_BYTES) || (hsize > 3'd2) ||
                       ((hsize == 3'd1) && haddr[0]) ||
                       ((hsize == 3'd2) && (haddr[1:0] != 2'b00));
  assign acc         = hreadyin & hreadyout & htrans[1];

  always_comb begin
    be_in = 4'b0000;
    case (hsize)
      3'd0:    be_in = 4'b0001 << haddr[1:0];
      3'd1:    be_in = haddr[1] ? 4'b1100 : 4'b0011;
      3'd2:    be_in = 4'b1111;
      default: be_in = 4'b0000;
    endcase
  end

`ifdef AHB_SLAVE_ERR_RESP_EN
  assign hreadyout = (state_q == ST_READY) || (state_q == ST_ERR2);
  assign hresp     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? 2'b01 : 2'b00;
`else
  assign hreadyout = (state_q == ST_READY);
  assign hresp     = 2'b00;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = ST_READY;
      end
`ifdef AHB_SLAVE_ERR_RESP_EN
      ST_ERR1: state_d = ST_ERR2;
`endif
      default: begin
        // READY and ERR2 accept identically
        state_d = ST_READY;
        if (acc && (WS != 3'd0)) begin
          state_d = ST_WAIT;
          cnt_d   = WS;
        end
`ifdef AHB_SLAVE_ERR_RESP_EN
        if (acc && illegal) begin
          state_d = ST_ERR1;
          cnt_d   = cnt_q;
        end
`endif
      end
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q <= ST_READY;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A write commits at the edge closing its data phase; a read accepted on that edge sees the merged word.
  assign commit   = hreadyout & pend.vld & pend.write & ~pend.err;
  assign wr_word  = merge(mem[pend.idx], hwdata, pend.be);
  assign fwd_word = (commit && (pend.idx == rd_idx)) ? merge(mem[rd_idx], hwdata, pend.be)
                                                     : mem[rd_idx];

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      pend   <= '0;
      hrdata <= '0;
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= '0;
    end else begin
      if (commit) mem[pend.idx] <= wr_word;
      if (hreadyout) begin
        pend.vld <= acc;
        if (acc) begin
          pend.write <= hwrite;
          pend.err   <= illegal;
          pend.be    <= be_in;
          pend.idx   <= rd_idx;
        end
      end
      if (acc) begin
        if (illegal)                        hrdata <= '0;
        else if (!hwrite && (WS == 3'd0))   hrdata <= fwd_word;
      end else if ((state_q == ST_WAIT) && (cnt_q == 3'd1) && !pend.write && !pend.err) begin
        hrdata <= mem[pend.idx];
      end
    end
  end

endmodule
